video_src_scheduler: RTL and testbench

Frame-synchronous scheduler that shares the single `video_cleaner` input between two video requesters (source 0 = core video, source 1 = alternate/menu video). It grants the datapath to one source at a time and performs switches only at a vertical-blank boundary of the outgoing source. Each newly granted source is muted for a programmable number of frames so that downstream sync cleanup and scalers re-lock on clean timing. It sits directly in front of `video_cleaner` and drives its R/G/B, HSync, VSync, HBlank and VBlank inputs.

---
 rtl/video_sched_pkg.sv | 45 ++++
 rtl/video_src_mux.sv | 54 +++++
 rtl/video_src_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_video_src_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_sched_pkg.sv
// ---------------------------------------------------------------------------
// video_sched_pkg
// Shared types and constants for the two-source video scheduler.
//   sched_state_t : scheduler FSM states
//   src_idx_t     : index of a video source (0 = core, 1 = alternate/menu)
//   vid_bus_t     : one pixel worth of video {rgb, hs, vs, hb, vb}
//   mux_mode_t    : output forcing mode of the registered source mux
// ---------------------------------------------------------------------------
package video_sched_pkg;

  localparam int MUTE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUTE   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  typedef logic [0:0] src_idx_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } vid_bus_t;

  // BLANK: nothing owns the datapath, syncs low and fully blanked.
  // MUTE : selected source's syncs pass, picture forced black and blanked.
  // PASS : selected source passes unmodified.
  typedef enum logic [1:0] {
    MODE_BLANK = 2'd0,
    MODE_MUTE  = 2'd1,
    MODE_PASS  = 2'd2
  } mux_mode_t;

  localparam vid_bus_t VID_BLANK = '{rgb: 24'd0, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};

  function automatic logic [1:0] src_onehot(input src_idx_t s);
    return (s == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/video_src_mux.sv
// ---------------------------------------------------------------------------
// video_src_mux
// Registered two-way video mux with blank/mute forcing. One register stage,
// advancing only on ce.
//   clk, srst   : clock and synchronous active-high reset
//   ce          : pixel enable; register holds when low
//   sel         : source to route
//   mode        : BLANK / MUTE / PASS forcing applied to the routed source
//   src0, src1  : source video buses
//   out_bus     : registered output bus
// ---------------------------------------------------------------------------
module video_src_mux
  import video_sched_pkg::*;
(
  input  logic      clk,
  input  logic      srst,
  input  logic      ce,
  input  src_idx_t  sel,
  input  mux_mode_t mode,
  input  vid_bus_t  src0,
  input  vid_bus_t  src1,
  output vid_bus_t  out_bus
);

  vid_bus_t w_src;
  vid_bus_t w_forced;
  vid_bus_t r_out;

  assign w_src = (sel == 1'b1) ? src1 : src0;

  always_comb begin
    w_forced = VID_BLANK;
    case (mode)
      MODE_MUTE: begin
        // Keep the sink's sync PLL fed while the picture stays black.
        w_forced.hs = w_src.hs;
        w_forced.vs = w_src.vs;
      end
      MODE_PASS: w_forced = w_src;
      default:   w_forced = VID_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_out <= VID_BLANK;
    end else if (ce) begin
      r_out <= w_forced;
    end
  end

  assign out_bus = r_out;

endmodule

// File: rtl/video_src_scheduler.sv
// ---------------------------------------------------------------------------
// video_src_scheduler
// Shares one video_cleaner input between two requesters. Ownership changes
// only at a vertical-blank boundary of the outgoing source, and each newly
// granted source is muted for MUTE_FRAMES of its own frames.
//   MUTE_FRAMES          : frames of black after a grant (1..15)
//   clk_vid, reset       : video clock, synchronous active-high reset
//   ce_pix               : shared pixel enable; all non-reset state advances on it
//   req[1:0]             : per-source display request (source 0 has priority)
//   grant[1:0], busy     : one-hot owner (0 when idle), switch in progress
//   src0_*, src1_*       : source pixel data and active-high syncs/blanks
//   out_*                : registered video towards the cleaner
// ---------------------------------------------------------------------------
module video_src_scheduler
  import video_sched_pkg::*;
#(
  parameter int MUTE_FRAMES = 2
)
(
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  output logic        busy,
  input  logic [23:0] src0_rgb,
  input  logic        src0_hs,
  input  logic        src0_vs,
  input  logic        src0_hb,
  input  logic        src0_vb,
  input  logic [23:0] src1_rgb,
  input  logic        src1_hs,
  input  logic        src1_vs,
  input  logic        src1_hb,
  input  logic        src1_vb,
  output logic [23:0] out_rgb,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_hb,
  output logic        out_vb
);

  localparam logic [MUTE_CNT_W-1:0] MUTE_LOAD = MUTE_CNT_W'(MUTE_FRAMES);
  localparam logic [MUTE_CNT_W-1:0] CNT_ONE   = MUTE_CNT_W'(1);

  sched_state_t            r_state, w_state_next;
  src_idx_t                r_sel, w_sel_next;
  logic [MUTE_CNT_W-1:0]   r_cnt, w_cnt_next;

  logic [1:0] w_vs, w_vb;
  logic [1:0] w_vs_rise, w_vb_rise;
  logic       w_win_valid;
  src_idx_t   w_win;
  logic       w_sw;
  mux_mode_t  w_mode;
  vid_bus_t   w_src0, w_src1, w_out;

  assign w_vs = {src1_vs, src0_vs};
  assign w_vb = {src1_vb, src0_vb};

  // Edge detectors run for both sources all the time, so the history of a
  // source is already valid the moment it becomes selected.
  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    logic r_vs_prev;
    logic r_vb_prev;

    always_ff @(posedge clk_vid) begin
      if (reset) begin
        r_vs_prev <= 1'b0;
        r_vb_prev <= 1'b0;
      end else if (ce_pix) begin
        r_vs_prev <= w_vs[gi];
        r_vb_prev <= w_vb[gi];
      end
    end

    assign w_vs_rise[gi] = w_vs[gi] & ~r_vs_prev;
    assign w_vb_rise[gi] = w_vb[gi] & ~r_vb_prev;
  end

  // Fixed priority: source 0 always wins when it asks.
  assign w_win_valid = |req;
  assign w_win       = req[0] ? 1'b0 : 1'b1;

  // Leave the current owner when it stops asking, or when source 1 owns the
  // display and the higher-priority source 0 asks.
  assign w_sw = !req[r_sel] || ((r_sel == 1'b1) && req[0]);

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_state_next = MUTE;
          w_sel_next   = w_win;
          w_cnt_next   = MUTE_LOAD;
        end
      end
      MUTE: begin
        // Nothing visible yet, so a switch request needs no VBlank wait.
        if (w_sw) begin
          if (w_win_valid) begin
            w_state_next = MUTE;
            w_sel_next   = w_win;
            w_cnt_next   = MUTE_LOAD;
          end else begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end
        end else if (w_vs_rise[r_sel]) begin
          if (r_cnt == CNT_ONE) begin
            w_state_next = ACTIVE;
          end
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
      end
      ACTIVE: begin
        if (w_sw) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A withdrawn switch takes precedence over a coincident VBlank edge.
        if (!w_sw) begin
          w_state_next = ACTIVE;
        end else if (w_vb_rise[r_sel]) begin
          if (w_win_valid) begin
            w_state_next = MUTE;
            w_sel_next   = w_win;
            w_cnt_next   = MUTE_LOAD;
          end else begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // The pixel sampled on a transition edge already obeys the new state.
  always_comb begin
    w_mode = MODE_BLANK;
    case (w_state_next)
      IDLE:    w_mode = MODE_BLANK;
      MUTE:    w_mode = MODE_MUTE;
      default: w_mode = MODE_PASS;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
    end else if (ce_pix) begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign w_src0 = {src0_rgb, src0_hs, src0_vs, src0_hb, src0_vb};
  assign w_src1 = {src1_rgb, src1_hs, src1_vs, src1_hb, src1_vb};

  video_src_mux u_mux (
    .clk     (clk_vid),
    .srst    (reset),
    .ce      (ce_pix),
    .sel     (w_sel_next),
    .mode    (w_mode),
    .src0    (w_src0),
    .src1    (w_src1),
    .out_bus (w_out)
  );

  assign out_rgb = w_out.rgb;
  assign out_hs  = w_out.hs;
  assign out_vs  = w_out.vs;
  assign out_hb  = w_out.hb;
  assign out_vb  = w_out.vb;

  assign grant = (r_state == IDLE) ? 2'b00 : src_onehot(r_sel);
  assign busy  = (r_state == MUTE) || (r_state == DRAIN);

endmodule

// File: tb/tb_video_src_scheduler.sv
// ---------------------------------------------------------------------------
// tb_video_src_scheduler
// Drives two free-running synthetic video sources, directed request phases
// and a randomized phase. A frame-level ownership model predicts every
// cycle's grant/busy/output; predictions go to a queue that a separate
// monitor pops and compares one clock edge later.
// ---------------------------------------------------------------------------
module tb_video_src_scheduler;

  localparam int MF = 2;
  localparam int W0 = 16, H0 = 8;
  localparam int W1 = 12, H1 = 6;
  localparam int VB_RISE0 = (H0 - 2) * W0;

  logic        clk_vid = 1'b0;
  logic        reset   = 1'b0;
  logic        ce_pix  = 1'b0;
  logic [1:0]  req     = 2'b00;
  logic [1:0]  grant;
  logic        busy;
  logic [23:0] src0_rgb = '0, src1_rgb = '0;
  logic        src0_hs = 1'b0, src0_vs = 1'b0, src0_hb = 1'b0, src0_vb = 1'b0;
  logic        src1_hs = 1'b0, src1_vs = 1'b0, src1_hb = 1'b0, src1_vb = 1'b0;
  logic [23:0] out_rgb;
  logic        out_hs, out_vs, out_hb, out_vb;

  always #5 clk_vid = ~clk_vid;

  video_src_scheduler #(.MUTE_FRAMES(MF)) dut (
    .clk_vid  (clk_vid),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .req      (req),
    .grant    (grant),
    .busy     (busy),
    .src0_rgb (src0_rgb),
    .src0_hs  (src0_hs),
    .src0_vs  (src0_vs),
    .src0_hb  (src0_hb),
    .src0_vb  (src0_vb),
    .src1_rgb (src1_rgb),
    .src1_hs  (src1_hs),
    .src1_vs  (src1_vs),
    .src1_hb  (src1_hb),
    .src1_vb  (src1_vb),
    .out_rgb  (out_rgb),
    .out_hs   (out_hs),
    .out_vs   (out_vs),
    .out_hb   (out_hb),
    .out_vb   (out_vb)
  );

  // Source raster positions (advance on every ce_pix).
  int p0 = 0;
  int p1 = 0;

  // Reference model: who owns the display, how many mute frames remain,
  // and whether the owner is being drained towards its next VBlank.
  int          m_owner = -1;
  int          m_left  = 0;
  bit          m_drain = 1'b0;
  logic [1:0]  m_vsp   = 2'b00;
  logic [1:0]  m_vbp   = 2'b00;
  logic [27:0] m_out   = {24'd0, 4'b0011};

  logic [30:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          stim_done = 1'b0;

  // {hs, vs, hb, vb} for raster position p of a w x h frame
  function automatic logic [3:0] sync_of(input int p, input int w, input int h);
    int x, y;
    x = p % w;
    y = p / w;
    return {(x >= w - 3), (y == h - 1), (x >= w - 4), (y >= h - 2)};
  endfunction

  task automatic tick(input logic ce, input logic rst, input logic [1:0] rq);
    logic [3:0]  s0, s1;
    logic [23:0] c0, c1;
    logic [1:0]  vs, vb, vsr, vbr;
    logic [27:0] sb;
    logic [1:0]  g;
    int          best;
    bit          want;
    @(negedge clk_vid);
    s0 = sync_of(p0, W0, H0);
    s1 = sync_of(p1, W1, H1);
    c0 = 24'($urandom);
    c1 = 24'($urandom);
    {src0_hs, src0_vs, src0_hb, src0_vb} = s0;
    {src1_hs, src1_vs, src1_hb, src1_vb} = s1;
    src0_rgb = c0;
    src1_rgb = c1;
    ce_pix = ce;
    reset  = rst;
    req    = rq;

    if (rst) begin
      m_owner = -1;
      m_left  = 0;
      m_drain = 1'b0;
      m_vsp   = 2'b00;
      m_vbp   = 2'b00;
      m_out   = {24'd0, 4'b0011};
    end else if (ce) begin
      vs   = {s1[2], s0[2]};
      vb   = {s1[0], s0[0]};
      vsr  = vs & ~m_vsp;
      vbr  = vb & ~m_vbp;
      best = rq[0] ? 0 : (rq[1] ? 1 : -1);
      want = (m_owner >= 0) && (!rq[m_owner] || (m_owner == 1 && rq[0]));
      if (m_owner < 0) begin
        if (best >= 0) begin
          m_owner = best;
          m_left  = MF;
        end
      end else if (m_left > 0) begin
        if (want) begin
          m_owner = best;
          m_left  = (best >= 0) ? MF : 0;
        end else if (vsr[m_owner]) begin
          m_left = m_left - 1;
        end
      end else if (!m_drain) begin
        if (want) m_drain = 1'b1;
      end else begin
        if (!want) begin
          m_drain = 1'b0;
        end else if (vbr[m_owner]) begin
          m_drain = 1'b0;
          m_owner = best;
          m_left  = (best >= 0) ? MF : 0;
        end
      end
      m_vsp = vs;
      m_vbp = vb;
      sb = (m_owner == 1) ? {c1, s1} : {c0, s0};
      if (m_owner < 0)      m_out = {24'd0, 4'b0011};
      else if (m_left > 0)  m_out = {24'd0, sb[3], sb[2], 2'b11};
      else                  m_out = sb;
    end

    if (ce) begin
      p0 = (p0 + 1) % (W0 * H0);
      p1 = (p1 + 1) % (W1 * H1);
    end

    g = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    exp_q.push_back({g, (m_left > 0) || m_drain, m_out});
  endtask

  task automatic run_until_p0(input int target, input logic [1:0] rq);
    int guard;
    guard = 0;
    while (p0 != target && guard < 1000) begin
      tick(1'b1, 1'b0, rq);
      guard++;
    end
    if (p0 != target) begin
      n_checks++;
      $display("FAIL align_timeout p0=%0d required=%0d", p0, target);
    end
  endtask

  // Monitor: one comparison per clock edge, just after the edge.
  initial begin
    logic [30:0] exp_v, act_v;
    int          txn;
    txn = 0;
    forever begin
      @(posedge clk_vid);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {grant, busy, out_rgb, out_hs, out_vs, out_hb, out_vb};
        n_checks++;
        txn++;
        if (act_v === exp_v) begin
          n_pass++;
          $display("txn %0d ok grant=%b busy=%b rgb=%h hs/vs/hb/vb=%b", txn,
                   act_v[30:29], act_v[28], act_v[27:4], act_v[3:0]);
        end else begin
          $display("FAIL txn %0d out: got grant=%b busy=%b rgb=%h sync=%b, required grant=%b busy=%b rgb=%h sync=%b",
                   txn, act_v[30:29], act_v[28], act_v[27:4], act_v[3:0],
                   exp_v[30:29], exp_v[28], exp_v[27:4], exp_v[3:0]);
        end
      end
    end
  end

  initial begin
    int          hold;
    logic [1:0]  rq_r;
    logic        ce_r, rst_r;

    // Reset, then source 0 requests: mute for MF frames, then pass-through.
    repeat (3) tick(1'b1, 1'b1, 2'b00);
    repeat (400) tick(1'b1, 1'b0, 2'b01);
    // Source 1 asks while source 0 owns: priority keeps source 0.
    repeat (100) tick(1'b1, 1'b0, 2'b11);
    // Drain then re-raise req[0] well before VBlank.
    run_until_p0(10, 2'b01);
    repeat (20) tick(1'b1, 1'b0, 2'b00);
    repeat (20) tick(1'b1, 1'b0, 2'b01);
    // Withdraw the switch exactly on the source 0 VBlank rise.
    run_until_p0(VB_RISE0 - 5, 2'b01);
    repeat (5) tick(1'b1, 1'b0, 2'b00);
    tick(1'b1, 1'b0, 2'b01);
    repeat (20) tick(1'b1, 1'b0, 2'b01);
    // Hand over to source 1 at the source 0 VBlank, then drop it while muting.
    run_until_p0(20, 2'b10);
    run_until_p0(VB_RISE0, 2'b10);
    repeat (20) tick(1'b1, 1'b0, 2'b10);
    repeat (5) tick(1'b1, 1'b0, 2'b00);
    // Back to source 0 active, freeze with ce low, then reset with ce low.
    repeat (400) tick(1'b1, 1'b0, 2'b01);
    repeat (10) tick(1'b0, 1'b0, 2'b01);
    tick(1'b0, 1'b1, 2'b01);
    tick(1'b0, 1'b0, 2'b01);

    // Randomized phase: random ce duty, long random request holds, rare resets.
    hold = 0;
    rq_r = 2'b00;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        rq_r = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 250);
      end
      hold--;
      ce_r  = ($urandom_range(0, 3) != 0);
      rst_r = ($urandom_range(0, 999) == 0);
      tick(ce_r, rst_r, rq_r);
    end

    @(posedge clk_vid);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
